// File: rtl/shift_add_mul_ctrl.sv
// shift_add_mul_ctrl: sequential 4x4 unsigned shift-add multiplier.
// A single full_adder_4_bit is time-shared over four CALC iterations under
// a small IDLE/CALC/DONE FSM with a start/busy/done handshake.
// Optional feature macro: MUL_ZERO_BYPASS_EN (zero operands skip CALC).
// DONE_PULSE=1 gives a one-cycle done; DONE_PULSE=0 holds done until the
// next accepted start.

// 4-bit ripple adder: the only arithmetic resource in the multiplier.
module full_adder_4_bit (
  input  logic [3:0] num1,
  input  logic [3:0] num2,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] carry;

  assign carry[0] = cin;

  // One full-adder cell per bit, carry rippling upward.
  genvar i;
  generate
    for (i = 0; i < 4; i++) begin : g_bit
      assign sum[i]     = num1[i] ^ num2[i] ^ carry[i];
      assign carry[i+1] = (num1[i] & num2[i]) | (carry[i] & (num1[i] ^ num2[i]));
    end
  endgenerate

  assign cout = carry[4];

endmodule

module shift_add_mul_ctrl #(
  parameter bit DONE_PULSE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] multiplicand,
  input  logic [3:0] multiplier,
  output logic [7:0] product,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] a;
  logic [3:0] q;
  logic [3:0] m;
  logic       c;
  logic [1:0] count;

  logic [3:0] addend;
  logic [3:0] sum;
  logic       cout;
  logic [8:0] shifted;

  // Partial product for this iteration: M when the current multiplier LSB is set.
  assign addend = q[0] ? m : 4'h0;

  // The carry register is always 0 after each shift, so feeding it to the
  // adder carry-in is the same as tying carry-in low.
  full_adder_4_bit u_adder (
    .num1 (a),
    .num2 (addend),
    .cin  (c),
    .sum  (sum),
    .cout (cout)
  );

  // Right shift of {carry, accumulator, multiplier} by one position.
  assign shifted = {cout, sum, q} >> 1;

  // Sequencer: captures operands, runs four add/shift steps, publishes the product.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      product <= 8'h00;
      busy    <= 1'b0;
      done    <= 1'b0;
      a       <= 4'h0;
      q       <= 4'h0;
      m       <= 4'h0;
      c       <= 1'b0;
      count   <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a     <= 4'h0;
            c     <= 1'b0;
            m     <= multiplicand;
            q     <= multiplier;
            count <= 2'd0;
            busy  <= 1'b1;
`ifdef MUL_ZERO_BYPASS_EN
            if ((multiplicand == 4'h0) || (multiplier == 4'h0)) begin
              state   <= DONE;
              product <= 8'h00;
              done    <= 1'b1;
            end else begin
              state <= CALC;
              done  <= 1'b0;
            end
`else
            state <= CALC;
            done  <= 1'b0;
`endif
          end
        end

        CALC: begin
          c     <= shifted[8];
          a     <= shifted[7:4];
          q     <= shifted[3:0];
          count <= count + 2'd1;
          if (count == 2'd3) begin
            state   <= DONE;
            product <= shifted[7:0];
            done    <= 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= ~DONE_PULSE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_mul_ctrl.sv
// tb_shift_add_mul_ctrl: directed bench for shift_add_mul_ctrl.
// Instance dut uses DONE_PULSE=1, instance dutHold uses DONE_PULSE=0.
// Expected products are queued when a start is driven and compared when done rises.
module tb_shift_add_mul_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] mcand;
  logic [3:0] mplier;
  logic [7:0] product;
  logic       busy;
  logic       done;

  logic       start2;
  logic [3:0] mcand2;
  logic [3:0] mplier2;
  logic [7:0] product2;
  logic       busy2;
  logic       done2;

  int tests;
  int failed;
  int cycleCount;

  logic [7:0] expQ[$];
  logic [7:0] exp2Q[$];

  shift_add_mul_ctrl #(.DONE_PULSE(1'b1)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplicand (mcand),
    .multiplier   (mplier),
    .product      (product),
    .busy         (busy),
    .done         (done)
  );

  shift_add_mul_ctrl #(.DONE_PULSE(1'b0)) dutHold (
    .clk          (clk),
    .reset        (reset),
    .start        (start2),
    .multiplicand (mcand2),
    .multiplier   (mplier2),
    .product      (product2),
    .busy         (busy2),
    .done         (done2)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rising-edge counter used to measure spacing between results.
  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive one start pulse at a falling edge and queue the exact product.
  task automatic applyStimulus(input logic [3:0] m, input logic [3:0] q);
    logic [7:0] e;
    e = {4'h0, m} * {4'h0, q};
    mcand  = m;
    mplier = q;
    start  = 1'b1;
    expQ.push_back(e);
    @(negedge clk);
    start  = 1'b0;
    mcand  = ~m;
    mplier = ~q;
  endtask

  // Wait (bounded) for done on the pulsed instance, counting falling edges.
  task automatic waitDone(output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    if (done !== 1'b1) checkOutput("done_timeout", {31'h0, done}, 32'h1);
  endtask

  task automatic popCheck(input string tag);
    logic [7:0] e;
    if (expQ.size() == 0) begin
      tests++;
      failed++;
      $error("[TB] FAIL %s observed=%0h expected=<scoreboard empty>", tag, product);
    end else begin
      e = expQ.pop_front();
      checkOutput(tag, {24'h0, product}, {24'h0, e});
    end
  endtask

  task automatic waitDone2();
    int n;
    logic [7:0] e;
    n = 0;
    while (done2 !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (done2 !== 1'b1) checkOutput("done2_timeout", {31'h0, done2}, 32'h1);
    if (exp2Q.size() == 0) begin
      tests++;
      failed++;
      $error("[TB] FAIL hold_product observed=%0h expected=<scoreboard empty>", product2);
    end else begin
      e = exp2Q.pop_front();
      checkOutput("hold_product", {24'h0, product2}, {24'h0, e});
    end
  endtask

  // Linear directed sequence covering every scenario.
  initial begin
    int cyc;
    int t1;
    int t2;
    tests      = 0;
    failed     = 0;
    cycleCount = 0;
    reset   = 1'b1;
    start   = 1'b0;
    mcand   = 4'h0;
    mplier  = 4'h0;
    start2  = 1'b0;
    mcand2  = 4'h0;
    mplier2 = 4'h0;

    repeat (2) @(negedge clk);
    checkOutput("reset_product", {24'h0, product}, 32'h0);
    checkOutput("reset_busy", {31'h0, busy}, 32'h0);
    checkOutput("reset_done", {31'h0, done}, 32'h0);
    checkOutput("reset_done2", {31'h0, done2}, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // 15 x 15: five-edge latency, single-cycle done.
    applyStimulus(4'hF, 4'hF);
    checkOutput("busy_calc", {31'h0, busy}, 32'h1);
    waitDone(cyc);
    checkOutput("latency_ff", cyc, 32'd4);
    popCheck("product_ff");
    checkOutput("busy_done", {31'h0, busy}, 32'h1);
    @(negedge clk);
    checkOutput("done_pulse_ff", {31'h0, done}, 32'h0);
    checkOutput("busy_idle", {31'h0, busy}, 32'h0);

    // Back-to-back 13 x 11 then 7 x 9, second start in the first IDLE cycle.
    applyStimulus(4'd13, 4'd11);
    waitDone(cyc);
    t1 = cycleCount;
    popCheck("product_13x11");
    @(negedge clk);
    checkOutput("done_pulse_13x11", {31'h0, done}, 32'h0);
    applyStimulus(4'd7, 4'd9);
    waitDone(cyc);
    t2 = cycleCount;
    popCheck("product_7x9");
    checkOutput("result_spacing", 32'(t2 - t1), 32'd6);
    @(negedge clk);
    checkOutput("done_pulse_7x9", {31'h0, done}, 32'h0);

    // 6 x 5 with stray starts during CALC and DONE.
    applyStimulus(4'd6, 4'd5);
    @(negedge clk);
    mcand  = 4'd3;
    mplier = 4'd3;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(cyc);
    popCheck("product_6x5");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("ignored_busy", {31'h0, busy}, 32'h0);
    checkOutput("ignored_done", {31'h0, done}, 32'h0);
    @(negedge clk);
    checkOutput("no_restart_busy", {31'h0, busy}, 32'h0);
    checkOutput("product_hold", {24'h0, product}, 32'h1E);

    // 9 x 9 aborted by asynchronous reset in the third CALC cycle.
    applyStimulus(4'd9, 4'd9);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_product", {24'h0, product}, 32'h0);
    checkOutput("async_busy", {31'h0, busy}, 32'h0);
    checkOutput("async_done", {31'h0, done}, 32'h0);
    expQ.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    applyStimulus(4'd2, 4'd3);
    waitDone(cyc);
    popCheck("product_2x3");
    @(negedge clk);

    // Zero multiplicand: bypass or full path depending on the build.
    applyStimulus(4'd0, 4'd12);
    waitDone(cyc);
`ifdef MUL_ZERO_BYPASS_EN
    checkOutput("latency_zero", cyc, 32'd0);
`else
    checkOutput("latency_zero", cyc, 32'd4);
`endif
    popCheck("product_zero");
    @(negedge clk);

    // Held done on the DONE_PULSE=0 instance.
    mcand2  = 4'd4;
    mplier2 = 4'd4;
    start2  = 1'b1;
    exp2Q.push_back(8'h10);
    @(negedge clk);
    start2 = 1'b0;
    waitDone2();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("done_held_%0d", i), {31'h0, done2}, 32'h1);
    end
    mcand2  = 4'd1;
    mplier2 = 4'd1;
    start2  = 1'b1;
    exp2Q.push_back(8'h01);
    @(negedge clk);
    start2 = 1'b0;
    checkOutput("done_clear_on_start", {31'h0, done2}, 32'h0);
    waitDone2();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
